// File: rtl/ctrl_fc_sched_if.sv
// Bus bundle between the fully-connected layer scheduler and its environment:
// the req/ack layer handshake with its operands, the ctrl_mac in_ctrl strobes,
// and the buffer addresses with the per-group lane mask.
interface ctrl_fc_sched_if #(
    parameter int CORE   = 8,
    parameter int AWIDTH = 12,
    parameter int CWIDTH = 10
);
    // Layer request and operands
    logic              req;
    logic [CWIDTH-1:0] total_in;
    logic [CWIDTH-1:0] total_out;
    logic [AWIDTH-1:0] in_offset;
    logic [AWIDTH-1:0] w_offset;
    logic [AWIDTH-1:0] out_offset;

    // Status
    logic              ack;
    logic              done;

    // ctrl_mac in_ctrl strobes
    logic              out_start;
    logic              out_valid;
    logic              out_stop;

    // Buffer addressing
    logic [AWIDTH-1:0] in_addr;
    logic [AWIDTH-1:0] w_addr;
    logic [AWIDTH-1:0] out_addr;
    logic [CORE-1:0]   lane_mask;

    // Requester side
    modport master (
        output req, total_in, total_out, in_offset, w_offset, out_offset,
        input  ack, done, out_start, out_valid, out_stop,
        input  in_addr, w_addr, out_addr, lane_mask
    );

    // Scheduler side
    modport slave (
        input  req, total_in, total_out, in_offset, w_offset, out_offset,
        output ack, done, out_start, out_valid, out_stop,
        output in_addr, w_addr, out_addr, lane_mask
    );
endinterface

// File: rtl/ctrl_fc_sched.sv
// Layer scheduler for the gobou fully-connected datapath.
// One accepted req walks the M output neurons in groups of CORE lanes. Each
// group gets one start / N x valid / stop burst on ctrl_mac's in_ctrl bus,
// followed by DRAIN idle cycles so the MAC/accumulator pipeline empties.
// The ctrl strobes, addresses and lane mask are registered from the state, so
// they trail the state by one cycle; done and ack are registered on the
// transition itself so they coincide with the DONE / IDLE states.
module ctrl_fc_sched #(
    parameter int CORE   = 8,
    parameter int AWIDTH = 12,
    parameter int CWIDTH = 10,
    parameter int DRAIN  = 3
) (
    input  logic           clk,
    input  logic           xrst,
    ctrl_fc_sched_if.slave bus
);

    localparam int DWIDTH = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_START,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Operands latched on the accepted request
    logic [CWIDTH-1:0] n_q, n_d;
    logic [CWIDTH-1:0] m_q, m_d;
    logic [AWIDTH-1:0] in_off_q, in_off_d;
    logic [AWIDTH-1:0] w_off_q, w_off_d;
    logic [AWIDTH-1:0] out_off_q, out_off_d;

    // Walk state
    logic [CWIDTH-1:0] groups_q, groups_d;   // G = ceil(M / CORE)
    logic [CWIDTH-1:0] g_q, g_d;             // current group
    logic [CWIDTH-1:0] i_q, i_d;             // beat within the burst
    logic [DWIDTH-1:0] dcnt_q, dcnt_d;       // drain cycle counter
    logic [AWIDTH-1:0] wbase_q, wbase_d;     // g*N, accumulated, no multiplier
    logic [AWIDTH-1:0] obase_q, obase_d;     // g*CORE, accumulated

    // Registered outputs
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              stop_q, stop_d;
    logic [AWIDTH-1:0] in_addr_q, in_addr_d;
    logic [AWIDTH-1:0] w_addr_q, w_addr_d;
    logic [AWIDTH-1:0] out_addr_q, out_addr_d;
    logic [CORE-1:0]   lane_mask_q, lane_mask_d;

    // Derived group geometry
    logic [CWIDTH:0]   m_round;
    logic [CWIDTH-1:0] rem;
    logic [CORE-1:0]   part_mask;
    logic              last_group;
    logic              last_beat;
    logic              drain_end;

    assign m_round    = {1'b0, m_q} + (CWIDTH+1)'(CORE - 1);
    assign rem        = m_q % CWIDTH'(CORE);
    assign last_group = (g_q == groups_q - CWIDTH'(1));
    assign last_beat  = (i_q == n_q - CWIDTH'(1));
    assign drain_end  = (dcnt_q == DWIDTH'(DRAIN - 1));

    // Low (M mod CORE) lanes of a partial last group
    always_comb begin
        part_mask = '0;
        for (int k = 0; k < CORE; k++) begin
            part_mask[k] = (CWIDTH'(k) < rem);
        end
    end

    // Next-state and next-output logic for the layer walk
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        n_d         = n_q;
        m_d         = m_q;
        in_off_d    = in_off_q;
        w_off_d     = w_off_q;
        out_off_d   = out_off_q;
        groups_d    = groups_q;
        g_d         = g_q;
        i_d         = i_q;
        dcnt_d      = dcnt_q;
        wbase_d     = wbase_q;
        obase_d     = obase_q;
        ack_d       = ack_q;
        done_d      = 1'b0;
        start_d     = 1'b0;
        valid_d     = 1'b0;
        stop_d      = 1'b0;
        in_addr_d   = in_addr_q;
        w_addr_d    = w_addr_q;
        out_addr_d  = out_addr_q;
        lane_mask_d = lane_mask_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    n_d       = bus.total_in;
                    m_d       = bus.total_out;
                    in_off_d  = bus.in_offset;
                    w_off_d   = bus.w_offset;
                    out_off_d = bus.out_offset;
                    ack_d     = 1'b0;
                    state_d   = S_PREP;
                end
            end

            S_PREP: begin
                groups_d = CWIDTH'(m_round / (CWIDTH+1)'(CORE));
                g_d      = '0;
                wbase_d  = w_off_q;
                obase_d  = out_off_q;
                if (n_q == '0 || m_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_START;
                end
            end

            S_START: begin
                start_d     = 1'b1;
                in_addr_d   = in_off_q;
                w_addr_d    = wbase_q;
                out_addr_d  = obase_q;
                lane_mask_d = (last_group && rem != '0) ? part_mask : '1;
                i_d         = '0;
                state_d     = S_MAC;
            end

            S_MAC: begin
                valid_d   = 1'b1;
                in_addr_d = in_off_q + AWIDTH'(i_q);
                w_addr_d  = wbase_q + AWIDTH'(i_q);
                if (last_beat) begin
                    stop_d  = 1'b1;
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + CWIDTH'(1);
                end
            end

            S_DRAIN: begin
                if (drain_end) begin
                    if (last_group) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        g_d     = g_q + CWIDTH'(1);
                        wbase_d = wbase_q + AWIDTH'(n_q);
                        obase_d = obase_q + AWIDTH'(CORE);
                        state_d = S_START;
                    end
                end else begin
                    dcnt_d = dcnt_q + DWIDTH'(1);
                end
            end

            S_DONE: begin
                ack_d       = 1'b1;
                lane_mask_d = '0;
                state_d     = S_IDLE;
            end

            default: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any layer in flight
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            m_q         <= '0;
            in_off_q    <= '0;
            w_off_q     <= '0;
            out_off_q   <= '0;
            groups_q    <= '0;
            g_q         <= '0;
            i_q         <= '0;
            dcnt_q      <= '0;
            wbase_q     <= '0;
            obase_q     <= '0;
            ack_q       <= 1'b1;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            stop_q      <= 1'b0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            out_addr_q  <= '0;
            lane_mask_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            in_off_q    <= in_off_d;
            w_off_q     <= w_off_d;
            out_off_q   <= out_off_d;
            groups_q    <= groups_d;
            g_q         <= g_d;
            i_q         <= i_d;
            dcnt_q      <= dcnt_d;
            wbase_q     <= wbase_d;
            obase_q     <= obase_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            stop_q      <= stop_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            out_addr_q  <= out_addr_d;
            lane_mask_q <= lane_mask_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.done      = done_q;
    assign bus.out_start = start_q;
    assign bus.out_valid = valid_q;
    assign bus.out_stop  = stop_q;
    assign bus.in_addr   = in_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.lane_mask = lane_mask_q;

endmodule
